// File: rtl/wsum_accum_pkg.sv
// Shared constants for the edge-preserving filter datapath: tap widths, divider operand
// widths and the accumulator bound check used by wsum_accum and the divider wrapper.
package wsum_accum_pkg;

    localparam int unsigned PIX_W      = 8;
    localparam int unsigned WT_W       = 4;
    localparam int unsigned NUM_W      = 16;
    localparam int unsigned DEN_W      = 8;
    localparam int unsigned TAPS_DEF   = 9;
    localparam int unsigned CENTER_DEF = 4;

    localparam longint unsigned NUM_MAX = (64'd1 << NUM_W) - 64'd1;
    localparam longint unsigned DEN_MAX = (64'd1 << DEN_W) - 64'd1;

    // True when a full window of worst-case taps fits the divider operands.
    function automatic bit bounds_ok(input int unsigned taps, input int unsigned pix_w,
                                     input int unsigned wt_w, input int unsigned center);
        longint unsigned wt_max;
        longint unsigned pix_max;
        longint unsigned n_taps;
        wt_max  = (64'd1 << wt_w) - 64'd1;
        pix_max = (64'd1 << pix_w) - 64'd1;
        n_taps  = longint'(taps);
        return (n_taps * wt_max <= DEN_MAX) && (n_taps * pix_max * wt_max <= NUM_MAX) &&
               (center < taps);
    endfunction

endpackage

// File: rtl/wsum_accum_if.sv
// Tap stream in, dividend/divisor result out; master drives taps, slave is the accumulator.
interface wsum_accum_if #(
    parameter int unsigned PIX_W = wsum_accum_pkg::PIX_W,
    parameter int unsigned WT_W  = wsum_accum_pkg::WT_W
);
    import wsum_accum_pkg::*;

    logic                 in_valid;
    logic                 in_sync;
    logic [PIX_W-1:0]     in_pix;
    logic [WT_W-1:0]      in_wt;
    logic                 out_valid;
    logic [NUM_W-1:0]     out_num;
    logic [DEN_W-1:0]     out_den;
    logic [PIX_W-1:0]     out_center;
    logic                 out_zero;

    modport master (
        output in_valid, in_sync, in_pix, in_wt,
        input  out_valid, out_num, out_den, out_center, out_zero
    );

    modport slave (
        input  in_valid, in_sync, in_pix, in_wt,
        output out_valid, out_num, out_den, out_center, out_zero
    );

endinterface

// File: rtl/mul_pix_wt.sv
// Registered unsigned pixel x weight multiplier; product updates only on enabled edges.
module mul_pix_wt #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned WT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic [PIX_W-1:0]      i_pix,
    input  logic [WT_W-1:0]       i_wt,
    output logic [PIX_W+WT_W-1:0] o_prod
);
    localparam int unsigned PROD_W = PIX_W + WT_W;

    logic [PROD_W-1:0] r_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
        end else if (i_en) begin
            r_prod <= PROD_W'(i_pix) * PROD_W'(i_wt);
        end
    end

    assign o_prod = r_prod;

endmodule

// File: rtl/wsum_accum.sv
// Streaming weighted-sum accumulator: sum(pix*wt) and sum(wt) over a TAPS-tap window plus
// the centre pixel, emitted as a one-cycle strobe two cycles after the last tap.
module wsum_accum #(
    parameter int unsigned TAPS   = wsum_accum_pkg::TAPS_DEF,
    parameter int unsigned PIX_W  = wsum_accum_pkg::PIX_W,
    parameter int unsigned WT_W   = wsum_accum_pkg::WT_W,
    parameter int unsigned CENTER = wsum_accum_pkg::CENTER_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    wsum_accum_if.slave bus
);
    import wsum_accum_pkg::*;

    if (!bounds_ok(TAPS, PIX_W, WT_W, CENTER)) begin : g_param_check
        $fatal(1, "wsum_accum: TAPS/PIX_W/WT_W/CENTER exceed accumulator bounds");
    end

    localparam int unsigned PROD_W = PIX_W + WT_W;
    localparam int unsigned CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] CENTER_IDX = CNT_W'(CENTER);

    logic [CNT_W-1:0]  r_tcnt;
    logic [CNT_W-1:0]  w_idx;
    logic [CNT_W-1:0]  w_tcnt_next;
    logic              r_s1_valid;
    logic              r_s1_first;
    logic              r_s1_last;
    logic [WT_W-1:0]   r_s1_wt;
    logic [PIX_W-1:0]  r_center_cap;
    logic [PROD_W-1:0] w_prod;
    logic [NUM_W-1:0]  r_acc_num;
    logic [DEN_W-1:0]  r_acc_den;
    logic [NUM_W-1:0]  w_sum_num;
    logic [DEN_W-1:0]  w_sum_den;
    logic              r_out_valid;
    logic [NUM_W-1:0]  r_out_num;
    logic [DEN_W-1:0]  r_out_den;
    logic [PIX_W-1:0]  r_out_center;
    logic              r_out_zero;

    // A synced tap is always tap 0; any partial window simply never reaches its last flag.
    always_comb begin
        w_idx       = bus.in_sync ? '0 : r_tcnt;
        w_tcnt_next = (w_idx == LAST_IDX) ? '0 : w_idx + CNT_W'(1);
    end

    mul_pix_wt #(
        .PIX_W (PIX_W),
        .WT_W  (WT_W)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (bus.in_valid),
        .i_pix  (bus.in_pix),
        .i_wt   (bus.in_wt),
        .o_prod (w_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt       <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_first   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_wt      <= '0;
            r_center_cap <= '0;
        end else begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_tcnt     <= w_tcnt_next;
                r_s1_wt    <= bus.in_wt;
                r_s1_first <= (w_idx == '0);
                r_s1_last  <= (w_idx == LAST_IDX);
                if (w_idx == CENTER_IDX) begin
                    r_center_cap <= bus.in_pix;
                end
            end
        end
    end

    // First tap reloads instead of adding, so windows chain with no bubble.
    always_comb begin
        w_sum_num = NUM_W'(w_prod);
        w_sum_den = DEN_W'(r_s1_wt);
        if (!r_s1_first) begin
            w_sum_num = r_acc_num + NUM_W'(w_prod);
            w_sum_den = r_acc_den + DEN_W'(r_s1_wt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_num    <= '0;
            r_acc_den    <= '0;
            r_out_valid  <= 1'b0;
            r_out_num    <= '0;
            r_out_den    <= '0;
            r_out_center <= '0;
            r_out_zero   <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                r_acc_num <= w_sum_num;
                r_acc_den <= w_sum_den;
            end
            if (r_s1_valid && r_s1_last) begin
                r_out_num    <= w_sum_num;
                r_out_den    <= w_sum_den;
                r_out_zero   <= (w_sum_den == '0);
                r_out_center <= r_center_cap;
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_num    = r_out_num;
    assign bus.out_den    = r_out_den;
    assign bus.out_center = r_out_center;
    assign bus.out_zero   = r_out_zero;

endmodule

// File: tb/tb_wsum_accum.sv
// Scenario bench for wsum_accum: a tap-level model pushes expected windows into a queue that
// each scenario pops when out_valid strobes.
module tb_wsum_accum;
    import wsum_accum_pkg::*;

    localparam int TAPS   = 9;
    localparam int CENTER = 4;

    typedef struct {
        logic [15:0] num;
        logic [7:0]  den;
        logic [7:0]  center;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    wsum_accum_if bus ();

    wsum_accum #(
        .TAPS   (TAPS),
        .PIX_W  (PIX_W),
        .WT_W   (WT_W),
        .CENTER (CENTER)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          m_tcnt = 0;
    int          m_num  = 0;
    int          m_den  = 0;
    int          m_center = 0;
    int unsigned cyc    = 0;
    int unsigned pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.out_valid === 1'b1) pulses <= pulses + 1;

    // Drive one accepted tap for one edge and advance the window model.
    task automatic drive_tap(input int pix, input int wt, input bit sync);
        int   idx;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_sync  = sync;
        bus.in_pix   = 8'(pix);
        bus.in_wt    = 4'(wt);
        idx = sync ? 0 : m_tcnt;
        if (idx == 0) begin
            m_num = 0;
            m_den = 0;
        end
        m_num += pix * wt;
        m_den += wt;
        if (idx == CENTER) m_center = pix;
        if (idx == TAPS - 1) begin
            e.num    = 16'(m_num);
            e.den    = 8'(m_den);
            e.center = 8'(m_center);
            exp_q.push_back(e);
            m_tcnt = 0;
        end else begin
            m_tcnt = idx + 1;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
    endtask

    task automatic idle(input int n, input bit sync_noise);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b0;
            bus.in_sync  = sync_noise;
            @(posedge clk);
            #1;
        end
        bus.in_sync = 1'b0;
    endtask

    task automatic test_reset();
        int seen = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b zero=%b, want 0 0", bus.out_valid, bus.out_zero);
        end
        checks++;
        if (bus.out_num !== 16'd0 || bus.out_den !== 8'd0 || bus.out_center !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: num=%0d den=%0d center=%0d, want 0 0 0",
                     bus.out_num, bus.out_den, bus.out_center);
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_idle_valid: %0d strobes with no input, want 0", seen);
        end
    endtask

    task automatic test_ramp();
        exp_t e;
        int   waited = 0;
        for (int i = 0; i < TAPS; i++) drive_tap(10 * (i + 1), 1, i == 0);
        while (bus.out_valid !== 1'b1 && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (waited != 1) begin
            errors++;
            $display("FAIL ramp_latency: strobe after %0d edges, want 1 after last-tap edge",
                     waited);
        end
        if (bus.out_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.out_num !== e.num || bus.out_num !== 16'd450) begin
                errors++;
                $display("FAIL ramp_num: got %0d, want %0d", bus.out_num, e.num);
            end
            checks++;
            if (bus.out_den !== e.den || bus.out_zero !== 1'b0) begin
                errors++;
                $display("FAIL ramp_den: got %0d zero=%b, want %0d zero=0",
                         bus.out_den, bus.out_zero, e.den);
            end
            checks++;
            if (bus.out_center !== e.center) begin
                errors++;
                $display("FAIL ramp_center: got %0d, want %0d", bus.out_center, e.center);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_num !== 16'd450) begin
            errors++;
            $display("FAIL ramp_pulse_hold: valid=%b num=%0d, want 0 450",
                     bus.out_valid, bus.out_num);
        end
    endtask

    task automatic test_max_back_to_back();
        int          got = 0;
        int unsigned t_first = 0;
        fork
            begin
                for (int w = 0; w < 2; w++)
                    for (int i = 0; i < TAPS; i++) drive_tap(255, 15, i == 0);
            end
            begin
                exp_t e;
                for (int c = 0; c < 40 && got < 2; c++) begin
                    @(posedge clk);
                    #1;
                    if (bus.out_valid === 1'b1) begin
                        got++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL max_unexpected_valid: strobe at cycle %0d", cyc);
                        end else begin
                            e = exp_q.pop_front();
                            if (bus.out_num !== e.num || bus.out_den !== e.den ||
                                bus.out_zero !== 1'b0) begin
                                errors++;
                                $display("FAIL max_result: num=%0d den=%0d zero=%b, want %0d %0d 0",
                                         bus.out_num, bus.out_den, bus.out_zero, e.num, e.den);
                            end
                        end
                        if (got == 1) begin
                            t_first = cyc;
                        end else begin
                            checks++;
                            if (cyc - t_first != TAPS) begin
                                errors++;
                                $display("FAIL max_spacing: strobes %0d cycles apart, want %0d",
                                         cyc - t_first, TAPS);
                            end
                        end
                    end
                end
            end
        join
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL max_count: %0d results, want 2", got);
        end
    endtask

    task automatic test_zero_weight();
        exp_t e;
        int   waited = 0;
        for (int i = 0; i < TAPS; i++) drive_tap((i == CENTER) ? 77 : 20 + i, 0, i == 0);
        while (bus.out_valid !== 1'b1 && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL zero_timeout: valid=%b after %0d edges, want 1", bus.out_valid, waited);
        end else begin
            e = exp_q.pop_front();
            if (bus.out_num !== e.num || bus.out_den !== e.den) begin
                errors++;
                $display("FAIL zero_sums: num=%0d den=%0d, want %0d %0d",
                         bus.out_num, bus.out_den, e.num, e.den);
            end
            checks++;
            if (bus.out_zero !== 1'b1) begin
                errors++;
                $display("FAIL zero_flag: got %b, want 1", bus.out_zero);
            end
            checks++;
            if (bus.out_center !== e.center) begin
                errors++;
                $display("FAIL zero_center: got %0d, want %0d", bus.out_center, e.center);
            end
        end
        idle(2, 1'b0);
    endtask

    task automatic test_sync_restart();
        exp_t        e;
        int unsigned p0;
        int          waited = 0;
        p0 = pulses;
        for (int i = 0; i < 5; i++) drive_tap(9, 7, i == 0);
        for (int i = 0; i < TAPS; i++) begin
            drive_tap(100, 2, i == 0);
            if (i == 3) idle(1, 1'b1);
        end
        while (bus.out_valid !== 1'b1 && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL sync_timeout: valid=%b after %0d edges, want 1", bus.out_valid, waited);
        end else begin
            e = exp_q.pop_front();
            if (bus.out_num !== e.num || bus.out_den !== e.den || bus.out_center !== e.center) begin
                errors++;
                $display("FAIL sync_result: num=%0d den=%0d center=%0d, want %0d %0d %0d",
                         bus.out_num, bus.out_den, bus.out_center, e.num, e.den, e.center);
            end
        end
        idle(4, 1'b0);
        checks++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL sync_count: %0d strobes, want 1", pulses - p0);
        end
    endtask

    task automatic test_gaps_back_to_back();
        int          got = 0;
        int unsigned p0;
        p0 = pulses;
        fork
            begin
                for (int i = 0; i < TAPS; i++) begin
                    drive_tap(4, 3, i == 0);
                    idle(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
                end
                for (int i = 0; i < TAPS; i++) begin
                    drive_tap(1, 1, i == 0);
                    idle(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
                end
            end
            begin
                exp_t e;
                for (int c = 0; c < 120 && got < 2; c++) begin
                    @(posedge clk);
                    #1;
                    if (bus.out_valid === 1'b1) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL gaps_unexpected_valid: strobe at cycle %0d", cyc);
                        end else begin
                            got++;
                            e = exp_q.pop_front();
                            if (bus.out_num !== e.num || bus.out_den !== e.den ||
                                bus.out_center !== e.center) begin
                                errors++;
                                $display("FAIL gaps_result: num=%0d den=%0d center=%0d, want %0d %0d %0d",
                                         bus.out_num, bus.out_den, bus.out_center,
                                         e.num, e.den, e.center);
                            end
                        end
                    end
                end
            end
        join
        idle(3, 1'b0);
        checks++;
        if (got != 2 || pulses - p0 != 2) begin
            errors++;
            $display("FAIL gaps_count: %0d results %0d strobes, want 2 2", got, pulses - p0);
        end
    endtask

    task automatic test_mid_window_reset();
        exp_t        e;
        int unsigned p0;
        int          waited = 0;
        for (int i = 0; i < 6; i++) drive_tap(50, 5, i == 0);
        #2 rst_n = 1'b0;
        m_tcnt = 0;
        exp_q.delete();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_num !== 16'd0 || bus.out_den !== 8'd0 ||
            bus.out_center !== 8'd0 || bus.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%b num=%0d den=%0d center=%0d zero=%b, want all 0",
                     bus.out_valid, bus.out_num, bus.out_den, bus.out_center, bus.out_zero);
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        p0 = pulses;
        for (int i = 0; i < TAPS; i++) drive_tap(2, 2, 1'b0);
        while (bus.out_valid !== 1'b1 && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL midreset_timeout: valid=%b after %0d edges, want 1",
                     bus.out_valid, waited);
        end else begin
            e = exp_q.pop_front();
            if (bus.out_num !== e.num || bus.out_den !== e.den || bus.out_center !== e.center) begin
                errors++;
                $display("FAIL midreset_result: num=%0d den=%0d center=%0d, want %0d %0d %0d",
                         bus.out_num, bus.out_den, bus.out_center, e.num, e.den, e.center);
            end
        end
        idle(4, 1'b0);
        checks++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL midreset_count: %0d strobes, want 1", pulses - p0);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_pix   = '0;
        bus.in_wt    = '0;
        test_reset();
        test_ramp();
        test_max_back_to_back();
        test_zero_weight();
        test_sync_restart();
        test_gaps_back_to_back();
        test_mid_window_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
